// File: rtl/down_counter_timer.sv
// down_counter_timer: loadable down-counter/timer with a valid/ready load,
// a one-cycle DONE pulse at terminal count, and optional auto-reload.
module down_counter_timer #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             LOAD_VALID,
   output logic             LOAD_READY,
   input  logic [WIDTH-1:0] LOAD_VALUE,
   input  logic             EN,
   input  logic             RELOAD,
   input  logic             ABORT,
   output logic [WIDTH-1:0] O,
   output logic             BUSY,
   output logic             DONE
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] rv_q, rv_d;
   logic             ready_q, ready_d;

   // Next-state and count/reload-value computation.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rv_d    = rv_q;
      case (state_q)
         ST_IDLE: begin
            if (LOAD_VALID && ready_q) begin
               cnt_d   = LOAD_VALUE;
               rv_d    = LOAD_VALUE;
               state_d = (LOAD_VALUE != '0) ? ST_RUN : ST_DONE;
            end
         end
         ST_RUN: begin
            if (ABORT) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else if (EN) begin
               // A count of 1 (or a defensive 0) terminates; never wrap below 0.
               if (cnt_q > CNT_ONE) begin
                  cnt_d = cnt_q - CNT_ONE;
               end else begin
                  cnt_d   = '0;
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            if (ABORT) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else if (RELOAD) begin
               cnt_d   = rv_q;
               state_d = (rv_q != '0) ? ST_RUN : ST_DONE;
            end else begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
      // READY mirrors the upcoming state so it is valid the cycle we enter IDLE.
      ready_d = (state_d == ST_IDLE);
   end

   // State, count, reload-value and ready registers.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         rv_q    <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rv_q    <= rv_d;
         ready_q <= ready_d;
      end
   end

   // Status outputs decoded straight from registered state.
   always_comb begin
      O          = cnt_q;
      LOAD_READY = ready_q;
      BUSY       = (state_q == ST_RUN) || (state_q == ST_DONE);
      DONE       = (state_q == ST_DONE);
   end

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed self-checking bench for down_counter_timer (WIDTH=4).
module tb_down_counter_timer;

   logic       CLK = 1'b0;
   logic       RESET;
   logic       LOAD_VALID;
   logic       LOAD_READY;
   logic [3:0] LOAD_VALUE;
   logic       EN;
   logic       RELOAD;
   logic       ABORT;
   logic [3:0] O;
   logic       BUSY;
   logic       DONE;

   int errors = 0;
   int checks = 0;

   down_counter_timer #(.WIDTH(4)) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .LOAD_VALID (LOAD_VALID),
      .LOAD_READY (LOAD_READY),
      .LOAD_VALUE (LOAD_VALUE),
      .EN         (EN),
      .RELOAD     (RELOAD),
      .ABORT      (ABORT),
      .O          (O),
      .BUSY       (BUSY),
      .DONE       (DONE)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [3:0] o_e, input logic busy_e,
                          input logic done_e, input logic ready_e);
      chk({tag, ".O"},     32'(O),          32'(o_e));
      chk({tag, ".BUSY"},  32'(BUSY),       32'(busy_e));
      chk({tag, ".DONE"},  32'(DONE),       32'(done_e));
      chk({tag, ".READY"}, 32'(LOAD_READY), 32'(ready_e));
   endtask

   // Advance one rising edge and settle 1 time unit past it.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic load(input logic [3:0] n);
      LOAD_VALUE = n;
      LOAD_VALID = 1'b1;
      step();
      LOAD_VALID = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      RESET = 1'b0; LOAD_VALID = 1'b0; LOAD_VALUE = '0;
      EN = 1'b0; RELOAD = 1'b0; ABORT = 1'b0;

      // Reset held for 3 edges
      #1;
      chk_all("rst0", 4'd0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk_all("rst_hold", 4'd0, 1'b0, 1'b0, 1'b0);
      end
      RESET = 1'b1;
      #1;
      chk_all("rel_pre_edge", 4'd0, 1'b0, 1'b0, 1'b0);
      step();
      chk_all("idle_ready", 4'd0, 1'b0, 1'b0, 1'b1);

      // Basic countdown N=5
      EN = 1'b1;
      load(4'd5);
      chk_all("n5_load", 4'd5, 1'b1, 1'b0, 1'b0);
      for (int i = 1; i <= 5; i++) begin
         step();
         chk_all("n5_cnt", 4'(5 - i), 1'b1, (i == 5), 1'b0);
      end
      step();
      chk_all("n5_idle", 4'd0, 1'b0, 1'b0, 1'b1);

      // Enable gap: N=3, EN low 2 cycles
      load(4'd3);
      chk_all("n3_load", 4'd3, 1'b1, 1'b0, 1'b0);
      step();
      chk_all("n3_c2", 4'd2, 1'b1, 1'b0, 1'b0);
      EN = 1'b0;
      step();
      chk_all("n3_hold1", 4'd2, 1'b1, 1'b0, 1'b0);
      step();
      chk_all("n3_hold2", 4'd2, 1'b1, 1'b0, 1'b0);
      EN = 1'b1;
      step();
      chk_all("n3_c1", 4'd1, 1'b1, 1'b0, 1'b0);
      step();
      chk_all("n3_done", 4'd0, 1'b1, 1'b1, 1'b0);
      step();
      chk_all("n3_idle", 4'd0, 1'b0, 1'b0, 1'b1);

      // Zero load
      load(4'd0);
      chk_all("n0_done", 4'd0, 1'b1, 1'b1, 1'b0);
      step();
      chk_all("n0_idle", 4'd0, 1'b0, 1'b0, 1'b1);

      // Auto-reload at max N=15: DONE every 16 cycles
      RELOAD = 1'b1;
      load(4'd15);
      chk_all("n15_load", 4'd15, 1'b1, 1'b0, 1'b0);
      for (int i = 1; i <= 15; i++) begin
         step();
         chk_all("n15_p1", 4'(15 - i), 1'b1, (i == 15), 1'b0);
      end
      step();
      chk_all("n15_reload", 4'd15, 1'b1, 1'b0, 1'b0);
      for (int i = 1; i <= 15; i++) begin
         step();
         chk_all("n15_p2", 4'(15 - i), 1'b1, (i == 15), 1'b0);
      end
      RELOAD = 1'b0;
      step();
      chk_all("n15_idle", 4'd0, 1'b0, 1'b0, 1'b1);

      // Abort in RUN with EN high at O=4
      load(4'd9);
      chk_all("n9_load", 4'd9, 1'b1, 1'b0, 1'b0);
      for (int i = 1; i <= 5; i++) begin
         step();
         chk_all("n9_cnt", 4'(9 - i), 1'b1, 1'b0, 1'b0);
      end
      ABORT = 1'b1;
      step();
      ABORT = 1'b0;
      chk_all("n9_abort", 4'd0, 1'b0, 1'b0, 1'b1);
      step();
      chk_all("n9_after", 4'd0, 1'b0, 1'b0, 1'b1);

      // Abort beats RELOAD in DONE
      RELOAD = 1'b1;
      load(4'd1);
      chk_all("n1_load", 4'd1, 1'b1, 1'b0, 1'b0);
      step();
      chk_all("n1_done", 4'd0, 1'b1, 1'b1, 1'b0);
      ABORT = 1'b1;
      step();
      ABORT = 1'b0;
      RELOAD = 1'b0;
      chk_all("n1_abort", 4'd0, 1'b0, 1'b0, 1'b1);

      // Async reset mid-run at O=7
      load(4'd12);
      chk_all("n12_load", 4'd12, 1'b1, 1'b0, 1'b0);
      for (int i = 1; i <= 5; i++) begin
         step();
         chk_all("n12_cnt", 4'(12 - i), 1'b1, 1'b0, 1'b0);
      end
      #3;
      RESET = 1'b0;
      LOAD_VALID = 1'b1;
      LOAD_VALUE = 4'd3;
      #1;
      chk_all("async_rst", 4'd0, 1'b0, 1'b0, 1'b0);
      step();
      chk_all("rst_load_blk", 4'd0, 1'b0, 1'b0, 1'b0);
      RESET = 1'b1;
      step();
      chk_all("rel_no_load", 4'd0, 1'b0, 1'b0, 1'b1);
      LOAD_VALID = 1'b0;
      step();
      chk_all("final_idle", 4'd0, 1'b0, 1'b0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
